// File: rtl/line_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_ctrl_if
//  Brief    : Pixel-source, line-FIFO write and frame-status signals of the
//             line fill controller, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface line_fill_ctrl_if #(
   parameter int DW     = 16,
   parameter int V_DISP = 720
);
   logic                      frame_start;
   logic [DW-1:0]             src_data;
   logic                      src_valid;
   logic                      src_ready;
   logic [11:0]               fifo_wr_cnt;
   logic                      fifo_full;
   logic                      fifo_wr_en;
   logic [DW-1:0]             fifo_wr_data;
   logic                      vs_out;
   logic [$clog2(V_DISP)-1:0] line_cnt;
   logic                      busy;
   logic                      frame_err;

   // The controller side
   modport slave (
      input  frame_start, src_data, src_valid, fifo_wr_cnt, fifo_full,
      output src_ready, fifo_wr_en, fifo_wr_data, vs_out, line_cnt, busy,
             frame_err
   );

   // The environment side: pixel source, FIFO and frame sequencing
   modport master (
      output frame_start, src_data, src_valid, fifo_wr_cnt, fifo_full,
      input  src_ready, fifo_wr_en, fifo_wr_data, vs_out, line_cnt, busy,
             frame_err
   );
endinterface
`default_nettype wire

// File: rtl/line_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : line_fill_ctrl
//  Brief    : Write-side controller of the per-line video FIFO. Moves pixels
//             into the FIFO in whole lines only, once there is room for a
//             complete line, and pulses vs_out after each frame's last line.
//  Revision : 1.0 - initial release
// ============================================================================
module line_fill_ctrl #(
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720,
   parameter int DW         = 16,
   parameter int FIFO_DEPTH = 2048,
   parameter int MARGIN     = 4,
   parameter int VS_W       = 4
) (
   input  logic            clk,
   input  logic            rst,
   line_fill_ctrl_if.slave bus
);

   localparam int H_W = $clog2(H_DISP);
   localparam int V_W = $clog2(V_DISP);
   localparam int P_W = $clog2(VS_W + 1);

   localparam logic [H_W-1:0] c_H_LAST = H_W'(H_DISP - 1);
   localparam logic [V_W-1:0] c_V_LAST = V_W'(V_DISP - 1);
   localparam logic [P_W-1:0] c_P_LAST = P_W'(VS_W - 1);
   // A line may start only when a full line plus the count-latency margin fits
   localparam logic [12:0]    c_THRESH = 13'(FIFO_DEPTH - H_DISP - MARGIN);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_FILL  = 3'd2,
      S_LEND  = 3'd3,
      S_FEND  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [H_W-1:0]  r_h_cnt;
   logic [V_W-1:0]  r_v_cnt;
   logic [P_W-1:0]  r_pulse_cnt;
   logic            r_wr_en;
   logic [DW-1:0]   r_wr_data;
   logic            r_frame_err;
   logic            w_src_ready;
   logic            w_vs;
   logic            w_accept;
   logic            w_room;

   // Room for one more line, and no write still in flight that the count
   // has not yet reflected
   assign w_room   = ({1'b0, bus.fifo_wr_cnt} <= c_THRESH) && !r_wr_en;
   assign w_accept = bus.src_valid && w_src_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state decode and state-derived handshake/pulse outputs
   always_comb begin
      w_state_nxt = r_state;
      w_src_ready = 1'b0;
      w_vs        = 1'b0;
      case (r_state)
         S_IDLE:  if (bus.frame_start) w_state_nxt = S_CHECK;
         S_CHECK: if (w_room) w_state_nxt = S_FILL;
         S_FILL: begin
            w_src_ready = !bus.fifo_full;
            if (bus.src_valid && !bus.fifo_full && (r_h_cnt == c_H_LAST))
               w_state_nxt = S_LEND;
         end
         S_LEND:  w_state_nxt = (r_v_cnt == c_V_LAST) ? S_FEND : S_CHECK;
         S_FEND: begin
            w_vs = 1'b1;
            if (r_pulse_cnt == c_P_LAST) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Registered FIFO write port: each accepted beat is written one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) r_wr_data <= bus.src_data;
      end
   end

   // Pixel, line and vs-pulse counters; all hold at their terminal values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_pulse_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE:  if (bus.frame_start) r_v_cnt <= '0;
            S_CHECK: r_h_cnt <= '0;
            S_FILL:  if (w_accept && (r_h_cnt != c_H_LAST)) r_h_cnt <= r_h_cnt + 1'b1;
            S_LEND:  if (r_v_cnt != c_V_LAST) r_v_cnt <= r_v_cnt + 1'b1;
            S_FEND: begin
               if (r_pulse_cnt == c_P_LAST) begin
                  r_pulse_cnt <= '0;
                  r_v_cnt     <= '0;
               end else begin
                  r_pulse_cnt <= r_pulse_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky record of a frame_start that arrived while a frame was running
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                       r_frame_err <= 1'b0;
      else if (bus.frame_start && r_state != S_IDLE) r_frame_err <= 1'b1;
   end

   assign bus.src_ready    = w_src_ready;
   assign bus.fifo_wr_en   = r_wr_en;
   assign bus.fifo_wr_data = r_wr_data;
   assign bus.vs_out       = w_vs;
   assign bus.line_cnt     = r_v_cnt;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.frame_err    = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_fill_ctrl
//  Brief    : Self-checking bench for line_fill_ctrl (8x3 frame) against a
//             cycle-rule reference model of the line/frame protocol.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_fill_ctrl;
   localparam int H      = 8;
   localparam int V      = 3;
   localparam int DW     = 16;
   localparam int DEPTH  = 2048;
   localparam int MARGIN = 4;
   localparam int VS_W   = 4;
   localparam int THRESH = DEPTH - H - MARGIN;
   localparam int FRAME  = H * V;
   localparam int NEVER  = 1 << 30;

   logic clk = 1'b0;
   logic rst = 1'b1;

   line_fill_ctrl_if #(.DW(DW), .V_DISP(V)) bus ();

   line_fill_ctrl #(
      .H_DISP(H), .V_DISP(V), .DW(DW), .FIFO_DEPTH(DEPTH),
      .MARGIN(MARGIN), .VS_W(VS_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycle numbers of the protocol events that gate
   // when the source may be served
   int          cyc        = 0;
   int          start_c    = -100;
   int          line_end_c = -100;
   int          final_c    = -100;
   int          room_c     = -100;
   int          beats      = 0;
   bit          in_frame   = 0;
   bit          done       = 0;
   bit          acc_prev   = 0;
   bit          err_exp    = 0;
   logic [DW-1:0] last_data = '0;
   int          valid_mode = 0;
   int          wr_count   = 0;
   int          vs_count   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs mid-cycle against the model, advance the
   // model, then drive the next cycle's source inputs after the edge.
   task automatic tick();
      int  gate;
      bit  rdy_e, vs_e, acc;
      @(negedge clk);
      cyc++;
      if (in_frame && done && cyc == final_c + 6) in_frame = 0;
      gate = start_c + 2;
      if (line_end_c + 3 > gate) gate = line_end_c + 3;
      if (room_c + 1 > gate)     gate = room_c + 1;
      rdy_e = in_frame && !rst && beats < FRAME && cyc >= gate && !bus.fifo_full;
      vs_e  = in_frame && done && cyc >= final_c + 2 && cyc <= final_c + 5;
      chk("src_ready", bus.src_ready, rdy_e);
      chk("fifo_wr_en", bus.fifo_wr_en, acc_prev);
      if (acc_prev) chk("fifo_wr_data", bus.fifo_wr_data, last_data);
      if (rst)      chk("wr_data_in_reset", bus.fifo_wr_data, 0);
      chk("vs_out", bus.vs_out, vs_e);
      chk("busy", bus.busy, in_frame && cyc > start_c);
      chk("frame_err", bus.frame_err, err_exp);
      if (rdy_e)         chk("line_cnt_fill", bus.line_cnt, beats / H);
      else if (vs_e)     chk("line_cnt_fend", bus.line_cnt, V - 1);
      else if (!in_frame) chk("line_cnt_idle", bus.line_cnt, 0);
      if (bus.fifo_wr_en === 1'b1) wr_count++;
      if (bus.vs_out === 1'b1)     vs_count++;
      acc = rdy_e && bus.src_valid;
      if (acc) begin
         last_data = bus.src_data;
         beats++;
         if (beats == FRAME) begin
            done    = 1;
            final_c = cyc;
         end else if (beats % H == 0) begin
            line_end_c = cyc;
         end
      end
      acc_prev = acc;
      if (bus.frame_start && !rst) begin
         if (in_frame) err_exp = 1;
         else begin
            in_frame   = 1;
            done       = 0;
            beats      = 0;
            start_c    = cyc;
            line_end_c = -100;
         end
      end
      @(posedge clk);
      #1;
      if (acc) bus.src_data = DW'($urandom);
      case (valid_mode)
         0:       bus.src_valid = 1'b1;
         1:       bus.src_valid = ~bus.src_valid;
         default: bus.src_valid = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic set_cnt(input int v);
      if (v <= THRESH && bus.fifo_wr_cnt > 12'(THRESH)) room_c = cyc + 1;
      if (v > THRESH) room_c = NEVER;
      bus.fifo_wr_cnt = 12'(v);
   endtask

   task automatic pulse_start();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      for (int i = 0; i < 300 && beats < n; i++) tick();
      chk("wait_beats_bound", beats, n);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && !done; i++) tick();
      chk("wait_done_bound", done, 1);
   endtask

   task automatic run_frame_out();
      for (int i = 0; i < 400 && in_frame; i++) tick();
      chk("idle_after_frame", bus.busy, 0);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.src_data    = DW'($urandom);
      bus.src_valid   = 1'b0;
      bus.fifo_wr_cnt = '0;
      bus.fifo_full   = 1'b0;

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Full frame, continuous source
      valid_mode = 0; wr_count = 0; vs_count = 0;
      pulse_start();
      wait_done();
      run_frame_out();
      chk("frame1_writes", wr_count, FRAME);
      chk("frame1_vs_len", vs_count, VS_W);

      // Source gaps, a 5-cycle backpressure pulse mid-line, then random valid
      valid_mode = 1; wr_count = 0; vs_count = 0;
      pulse_start();
      wait_beats(10);
      bus.fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("ready_low_while_full", bus.src_ready, 0);
      end
      bus.fifo_full = 1'b0;
      valid_mode = 2;
      wait_done();
      run_frame_out();
      chk("frame2_writes", wr_count, FRAME);

      // Space gating, then frame_start during FILL and on the last FEND cycle
      valid_mode = 0; wr_count = 0; vs_count = 0;
      set_cnt(THRESH + 1);
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("gate_hold_ready", bus.src_ready, 0);
      end
      set_cnt(THRESH);
      chk("gate_same_cycle_ready", bus.src_ready, 0);
      tick();
      chk("gate_release_ready", bus.src_ready, 1);
      wait_beats(12);
      pulse_start();
      chk("frame_err_set", bus.frame_err, 1);
      wait_done();
      for (int i = 0; i < 20 && cyc < final_c + 4; i++) tick();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      run_frame_out();
      for (int i = 0; i < 3; i++) tick();
      chk("late_start_ignored", bus.busy, 0);
      chk("frame3_writes", wr_count, FRAME);
      chk("frame3_vs_len", vs_count, VS_W);
      chk("frame_err_sticky", bus.frame_err, 1);

      // Asynchronous reset three beats into a line
      set_cnt(0);
      valid_mode = 0;
      pulse_start();
      wait_beats(3);
      #2 rst = 1'b1;
      #1;
      chk("rst_src_ready", bus.src_ready, 0);
      chk("rst_wr_en", bus.fifo_wr_en, 0);
      chk("rst_wr_data", bus.fifo_wr_data, 0);
      chk("rst_vs_out", bus.vs_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_line_cnt", bus.line_cnt, 0);
      in_frame = 0; done = 0; acc_prev = 0; err_exp = 0; beats = 0;
      tick();
      tick();
      rst = 1'b0;
      wr_count = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("no_writes_after_rst", wr_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/line_fill_ctrl.md
# line_fill_ctrl

Write-side controller for the per-line video FIFO. It accepts a pixel stream from the frame-buffer read path and writes it into the line FIFO only in whole lines, and only when the FIFO has room for a complete line. After the last line of each frame has been written, it pulses a frame-boundary `vs` so the read-side aligner can restart its frame timing.

## Interface
- `H_DISP`, 1280, pixels per line and FIFO words per line.
- `V_DISP`, 720, lines per frame.
- `DW`, 16, pixel and FIFO data width.
- `FIFO_DEPTH`, 2048, FIFO capacity in words.
- `MARGIN`, 4, extra free words required before a line starts, to cover count latency.
- `VS_W`, 4, width of the `vs_out` pulse in clk cycles.
- `clk` in 1: clock. Every signal is synchronous to it.
- `rst` in 1: reset, asynchronous, active-high.
- `frame_start` in 1: single-cycle pulse that arms capture of a new frame.
- `src_data` in DW: pixel data.
- `src_valid` in 1: source has a valid pixel.
- `src_ready` out 1: block accepts a pixel. A beat transfers when `src_valid && src_ready`.
- `fifo_wr_cnt` in 12: write-side FIFO word count.
- `fifo_full` in 1: FIFO full flag.
- `fifo_wr_en` out 1: FIFO write strobe, registered.
- `fifo_wr_data` out DW: FIFO write data, registered.
- `vs_out` out 1: end-of-frame pulse to the read side.
- `line_cnt` out $clog2(V_DISP): index of the line currently being filled.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_err` out 1: sticky flag for a `frame_start` received while not in IDLE. Cleared only by `rst`.

## Operation
- States:
  - IDLE: `src_ready`=0. On `frame_start`, clear `v_cnt` and go to CHECK.
  - CHECK: `src_ready`=0; clear `h_cnt`. When `fifo_wr_cnt <= FIFO_DEPTH - H_DISP - MARGIN` and `fifo_wr_en`=0, go to FILL.
  - FILL:
    - `src_ready = !fifo_full` (combinational from state and `fifo_full`).
    - Each accepted beat registers `fifo_wr_data <= src_data`, sets `fifo_wr_en`=1 for the next cycle, and increments `h_cnt`.
    - When the beat with `h_cnt == H_DISP-1` is accepted, go to LEND.
  - LEND: one cycle; `src_ready`=0.
    - If `v_cnt == V_DISP-1`: go to FEND.
    - Otherwise: `v_cnt <= v_cnt+1`, go to CHECK.
  - FEND: `vs_out`=1 for exactly `VS_W` cycles, tracked by a pulse counter. Then clear `v_cnt` and go to IDLE.
- `line_cnt` = `v_cnt`.
- Exactly `H_DISP` writes occur per line and `H_DISP*V_DISP` writes per frame. No partial line is ever started.
- A `frame_start` outside IDLE is ignored, except that it sets `frame_err`. A `frame_start` in the same cycle that FEND exits to IDLE is also ignored.
- `fifo_full` asserted during FILL stalls acceptance without losing data. The already-registered write still completes; if that write overflows, it is the FIFO's protection, not this block's.
- Counters saturate at their terminal values and never wrap mid-line.
- Width rules:
  - `h_cnt` is $clog2(H_DISP) bits; `v_cnt` is $clog2(V_DISP) bits.
  - The threshold compare is done in 13-bit unsigned arithmetic.
  - The parameters guarantee `H_DISP + MARGIN <= FIFO_DEPTH`.
- Reset takes effect immediately from any state, including mid-line:
  - State returns to IDLE.
  - All counters clear.
  - `src_ready`, `fifo_wr_en`, `vs_out`, `busy` and `frame_err` go to 0; `fifo_wr_data` goes to 0.
  - A partially written line is not completed. The FIFO must be reset alongside this block.

## Timing
- Latency from the accepting beat to `fifo_wr_en`/`fifo_wr_data` is 1 cycle. Sustained throughput is 1 word per cycle.
- From `frame_start`:
  - Cycle 1: CHECK.
  - Earliest first `src_ready`: cycle 2, if the FIFO already has room.
  - Earliest first `fifo_wr_en`: cycle 3.
- Line overhead is at least 2 idle cycles between lines (LEND plus CHECK). Extra cycles are added while FIFO space is below the threshold.
- `vs_out` rises 1 cycle after LEND of the last line. At that point the final write of the line has already been presented to the FIFO.
- `busy` rises the cycle after `frame_start` and falls on entry to IDLE.

## Test plan
- Reset mid-FILL (set `H_DISP`=8, `V_DISP`=2; assert `rst` after 3 beats): all outputs 0 the same cycle, state IDLE, no further writes.
- Full frame (set `H_DISP`=8, `V_DISP`=3; `src_valid` held at 1; FIFO drained freely): exactly 24 writes with data equal to the source sequence. `vs_out` is high for 4 cycles starting 1 cycle after the 3rd LEND. `line_cnt` steps 0,1,2.
- Space gating (`fifo_wr_cnt` held at `FIFO_DEPTH-H_DISP-MARGIN+1`): `src_ready` stays 0. Lowering the count by 1 raises `src_ready` 1 cycle later.
- Backpressure (pulse `fifo_full` for 5 cycles mid-line): `src_ready` is 0 during the pulse and the line still totals `H_DISP` writes with no duplicated or dropped data.
- Source gaps (`src_valid` toggling 1,0,1,0): writes appear only for accepted beats, each 1 cycle later.
- `frame_start` during FILL: `frame_err`=1 and stays sticky; the frame completes with the normal write count and the single normal `vs_out` pulse.
